// File: rtl/dir_pkg.sv
// Shared direction codes, FIFO depth and repeat-state encoding for dir_event_tx.
package dir_pkg;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    LEFT  = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  localparam int FIFO_DEPTH = 4;

  // Fixed priority among simultaneous presses: right > left > up > down.
  function automatic dir_e prio_pick(input logic [3:0] p);
    if (p[0])      return RIGHT;
    else if (p[1]) return LEFT;
    else if (p[2]) return UP;
    else           return DOWN;
  endfunction

endpackage

// File: rtl/dir_debounce.sv
// One-button debouncer: level after 4 consecutive high samples, press on its rising edge.
// Latency: level 4 edges after raw rises; press is combinational from the registered level.
module dir_debounce (
  input  logic clk_20,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  logic [3:0] sr_q, sr_d;
  logic       prev_q, prev_d;

  always_comb begin
    sr_d   = {sr_q[2:0], raw};
    prev_d = &sr_q;
  end

  always_ff @(posedge clk_20 or posedge rst) begin
    if (rst) begin
      sr_q   <= 4'b0000;
      prev_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      prev_q <= prev_d;
    end
  end

  assign level = &sr_q;
  assign press = level & ~prev_q;

endmodule

// File: rtl/dir_event_tx.sv
// Debounced direction-button event source into a 4-entry FIFO; press enqueued 5 edges after raw rises.
// Valid/ready output; pushes into a full FIFO without a pop are dropped and set sticky overflow. Auto-repeat: DIR_EVENT_AUTOREPEAT_EN.
module dir_event_tx
  import dir_pkg::*;
#(
  parameter int REPEAT_DELAY  = 48,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic       clk_20,
  input  logic       rst,
  input  logic       right,
  input  logic       left,
  input  logic       up,
  input  logic       down,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [1:0] ev_dir,
  output logic [3:0] held,
  output logic [2:0] fifo_count,
  output logic       overflow
);

  logic [3:0] raw;
  logic [3:0] level;
  logic [3:0] press;
  logic       press_vld;
  dir_e       press_dir;
  logic       push_vld;
  dir_e       push_dir;

  assign raw = {down, up, left, right};

  for (genvar g = 0; g < 4; g++) begin : g_deb
    dir_debounce u_deb (
      .clk_20 (clk_20),
      .rst    (rst),
      .raw    (raw[g]),
      .level  (level[g]),
      .press  (press[g])
    );
  end

  assign press_vld = |press;
  assign press_dir = prio_pick(press);

`ifdef DIR_EVENT_AUTOREPEAT_EN
  rep_state_e  state_q, state_d;
  dir_e        act_q, act_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rep_push;

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    cnt_d    = cnt_q + 16'd1;
    rep_push = 1'b0;
    // A fresh press always wins over a repeat due in the same cycle.
    if (press_vld) begin
      state_d = HOLD;
      act_d   = press_dir;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        HOLD: begin
          if (!level[act_q]) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
          end else if (cnt_q == 16'(REPEAT_DELAY - 1)) begin
            state_d  = REPEAT;
            rep_push = 1'b1;
            cnt_d    = 16'd0;
          end
        end
        REPEAT: begin
          if (!level[act_q]) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
          end else if (cnt_q == 16'(REPEAT_PERIOD - 1)) begin
            rep_push = 1'b1;
            cnt_d    = 16'd0;
          end
        end
        default: cnt_d = 16'd0;
      endcase
    end
  end

  always_ff @(posedge clk_20 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= RIGHT;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
    end
  end

  assign push_vld = press_vld | rep_push;
  assign push_dir = press_vld ? press_dir : act_q;
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;

  assign push_vld = press_vld;
  assign push_dir = press_dir;
`endif

  dir_e       mem_q [FIFO_DEPTH];
  dir_e       mem_d [FIFO_DEPTH];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic       full;
  logic       pop;
  logic       wr_en;

  assign full  = (count_q == 3'(FIFO_DEPTH));
  assign pop   = (count_q != 3'd0) && ev_ready;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign wr_en = push_vld && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push_vld && full && !pop);
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_dir;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_20 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= RIGHT;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ev_valid   = (count_q != 3'd0);
  assign ev_dir     = mem_q[rd_ptr_q];
  assign held       = level;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_dir_event_tx.sv
// Directed bench for dir_event_tx: press latency, priority, FIFO full/overflow, reset, auto-repeat.
module tb_dir_event_tx;

  logic       clk_20 = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       ev_ready;
  logic       ev_valid;
  logic [1:0] ev_dir;
  logic [3:0] held;
  logic [2:0] fifo_count;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  dir_event_tx #(
    .REPEAT_DELAY  (6),
    .REPEAT_PERIOD (3)
  ) dut (
    .clk_20     (clk_20),
    .rst        (rst),
    .right      (btn[0]),
    .left       (btn[1]),
    .up         (btn[2]),
    .down       (btn[3]),
    .ev_ready   (ev_ready),
    .ev_valid   (ev_valid),
    .ev_dir     (ev_dir),
    .held       (held),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk_20 = ~clk_20;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, returning 1 time unit after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_20);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Raw high for 5 edges (enqueued at the 5th), then low long enough to re-arm.
  task automatic press(input int b);
    btn[b] = 1'b1;
    step(5);
    btn[b] = 1'b0;
    step(3);
  endtask

  initial begin
    int         nev;
    int         maxc;
    logic       exp_v;
    logic [1:0] exp4 [4];

    rst      = 1'b1;
    btn      = 4'b0000;
    ev_ready = 1'b0;
    step(2);
    chk("rst_valid", ev_valid, 0);
    chk("rst_dir", ev_dir, 0);
    chk("rst_held", held, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;

    // Up held for 8 sampled edges with ready high: one event, visible only after edge 5.
    ev_ready = 1'b1;
    btn[2]   = 1'b1;
    nev      = 0;
    for (int k = 1; k <= 14; k++) begin
      step(1);
      chk($sformatf("up_valid_e%0d", k), ev_valid, (k == 5));
      if (ev_valid) nev++;
      if (k == 4) chk("up_held", held, 4'b0100);
      if (k == 5) chk("up_dir", ev_dir, 2);
      if (k == 8) btn[2] = 1'b0;
    end
    chk("up_event_count", nev, 1);

    // Right and down together: only right is queued.
    ev_ready = 1'b0;
    btn      = 4'b1001;
    maxc     = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (fifo_count > maxc) maxc = fifo_count;
      if (k == 5) chk("simul_dir", ev_dir, 0);
      if (k == 6) btn = 4'b0000;
    end
    chk("simul_peak", maxc, 1);
    ev_ready = 1'b1;
    step(1);
    chk("simul_drained", fifo_count, 0);
    ev_ready = 1'b0;

    // Five left presses into a stalled FIFO: fifth is dropped.
    for (int i = 0; i < 5; i++) begin
      press(1);
      if (i == 3) begin
        chk("fill_count4", fifo_count, 4);
        chk("fill_ovf0", overflow, 0);
      end
    end
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_valid%0d", i), ev_valid, 1);
      chk($sformatf("drain_dir%0d", i), ev_dir, 1);
      step(1);
    end
    chk("drain_empty", ev_valid, 0);
    chk("ovf_sticky", overflow, 1);
    ev_ready = 1'b0;

    // Full FIFO with push and pop in the same cycle.
    do_reset();
    chk("ovf_cleared", overflow, 0);
    for (int i = 0; i < 4; i++) press(1);
    chk("full_count", fifo_count, 4);
    btn[2] = 1'b1;
    step(4);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    btn[2]   = 1'b0;
    chk("pushpop_count", fifo_count, 4);
    chk("pushpop_ovf", overflow, 0);
    exp4 = '{2'd1, 2'd1, 2'd1, 2'd2};
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pushpop_dir%0d", i), ev_dir, exp4[i]);
      step(1);
    end
    chk("pushpop_empty", fifo_count, 0);
    ev_ready = 1'b0;
    step(3);

    // Asynchronous reset with 3 queued; right held through release.
    for (int i = 0; i < 3; i++) press(0);
    chk("pre_rst_count", fifo_count, 3);
    btn[0] = 1'b1;
    rst    = 1'b1;
    #1;
    chk("async_rst_valid", ev_valid, 0);
    chk("async_rst_count", fifo_count, 0);
    step(1);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk($sformatf("rel_valid_e%0d", k), ev_valid, (k == 5));
    end
    chk("rel_dir", ev_dir, 0);
    btn[0] = 1'b0;
    step(3);
    do_reset();

    // Down held 20 edges, ready high.
    ev_ready = 1'b1;
    btn[3]   = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step(1);
`ifdef DIR_EVENT_AUTOREPEAT_EN
      exp_v = (k == 5) || (k == 11) || (k == 14) || (k == 17) || (k == 20);
`else
      exp_v = (k == 5);
`endif
      chk($sformatf("rep_valid_e%0d", k), ev_valid, exp_v);
      if (exp_v) chk($sformatf("rep_dir_e%0d", k), ev_dir, 3);
      if (k == 20) btn[3] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
